// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the bus master.
// Holds the byte-level FSM state encoding, the ACK/NACK line levels,
// the position of the R/W bit in the address byte and the bit-counter
// width with its milestone values.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } i2c_state_t;

   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;
   localparam int   RW_BIT = 0;
   localparam int   CNT_W  = 4;

   // Bit-counter milestones: value seen on the 8th data rise, value after
   // 8 rises (ACK slot), value after the ACK clock rise.
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);
   localparam logic [CNT_W-1:0] BYTE_END = CNT_W'(8);
   localparam logic [CNT_W-1:0] ACK_END  = CNT_W'(9);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one asynchronous I2C line: two flops to settle
// metastability, then a history flop so edges can be decoded.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   line_i     : raw bus line
//   level      : synchronised line level
//   rise, fall : single-cycle edge flags derived from level vs history
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic hist;

   // The pipeline resets to the idle-bus level (high) so that releasing
   // reset on a quiet bus never produces a phantom edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b1;
         level <= 1'b1;
         hist  <= 1'b1;
      end else begin
         meta  <= line_i;
         level <= meta;
         hist  <= level;
      end
   end

   assign rise = level & ~hist;
   assign fall = ~level & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target: detects START/STOP, matches its 7-bit address, ACKs, and
// serves a byte-wide register space held outside this block.
// Writes are pointer-then-data with auto-increment; reads stream bytes
// from the current pointer.
// Ports:
//   clk, rst_n   : system clock (>=16x SCL), async active-low reset
//   scl_i, sda_i : asynchronous bus lines
//   sda_oe       : 1 pulls SDA low, 0 releases it
//   wr_valid     : one-cycle strobe with wr_reg/wr_data
//   rd_reg       : index of the next byte to transmit
//   rd_data      : contents of rd_reg (combinational from outside)
//   busy         : high from address match until STOP, or until the
//                  next START after a read NACK
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR   = 7'h50,
   parameter int         REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              wr_valid,
   output logic [REG_AW-1:0] wr_reg,
   output logic [7:0]        wr_data,
   output logic [REG_AW-1:0] rd_reg,
   input  logic [7:0]        rd_data,
   output logic              busy
);

   localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

   logic              scl, scl_rise, scl_fall;
   logic              sda, sda_rise, sda_fall;
   logic              start_det, stop_det;
   i2c_state_t        state, next_state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [7:0]        shift_reg;
   logic [7:0]        rx_byte;
   logic [REG_AW-1:0] ptr;
   logic              rw;
   logic              addr_match;
   logic              sda_oe_d;

   i2c_line_sync u_scl_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (scl_i),
      .level  (scl),
      .rise   (scl_rise),
      .fall   (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (sda_i),
      .level  (sda),
      .rise   (sda_rise),
      .fall   (sda_fall)
   );

   // Bus conditions are SDA edges while SCL is high; both lines share the
   // same synchroniser depth so they stay aligned to each other.
   assign start_det  = scl & sda_fall;
   assign stop_det   = scl & sda_rise;

   // The byte as it will look once the current SDA level is shifted in.
   assign rx_byte    = {shift_reg[6:0], sda};
   assign addr_match = (rx_byte[7:1] == ADDR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode. START/STOP are checked first so they win over
   // any SCL edge seen in the same cycle.
   always_comb begin
      next_state = state;
      if (stop_det) begin
         next_state = ST_IDLE;
      end else if (start_det) begin
         next_state = ST_ADDR;
      end else begin
         case (state)
            ST_ADDR:
               if (scl_rise && bit_cnt == LAST_BIT)
                  next_state = addr_match ? ST_ADDR_ACK : ST_IDLE;
            ST_ADDR_ACK:
               if (scl_fall && bit_cnt == ACK_END)
                  next_state = rw ? ST_RDATA : ST_PTR;
            ST_PTR:
               if (scl_rise && bit_cnt == LAST_BIT)
                  next_state = ST_PTR_ACK;
            ST_PTR_ACK:
               if (scl_fall && bit_cnt == ACK_END)
                  next_state = ST_WDATA;
            ST_WDATA:
               if (scl_rise && bit_cnt == LAST_BIT)
                  next_state = ST_WDATA_ACK;
            ST_WDATA_ACK:
               if (scl_fall && bit_cnt == ACK_END)
                  next_state = ST_WDATA;
            ST_RDATA:
               if (scl_fall && bit_cnt == BYTE_END)
                  next_state = ST_RDATA_ACK;
            ST_RDATA_ACK:
               if (scl_rise)
                  next_state = (sda == ACK) ? ST_RDATA : ST_IGNORE;
            default:
               next_state = state;
         endcase
      end
   end

   // Output decode. SDA only changes on SCL falling edges: the ACK slot
   // is pulled low after the 8th data fall and released after the ACK
   // clock; read bits are driven inverted because SDA is open-drain.
   // A read byte's MSB goes out on the same fall that ends the address
   // ACK, or on the first fall after a master ACK reloaded the register.
   always_comb begin
      rd_reg   = ptr;
      sda_oe_d = sda_oe;
      if (start_det || stop_det) begin
         sda_oe_d = 1'b0;
      end else if (scl_fall) begin
         case (state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
               if (bit_cnt == BYTE_END)
                  sda_oe_d = ~ACK;
               else if (bit_cnt == ACK_END)
                  sda_oe_d = (state == ST_ADDR_ACK && rw) ? ~rd_data[7] : 1'b0;
            end
            ST_RDATA: begin
               if (bit_cnt == '0)
                  sda_oe_d = ~shift_reg[7];
               else if (bit_cnt == BYTE_END)
                  sda_oe_d = 1'b0;
               else
                  sda_oe_d = ~shift_reg[6];
            end
            default:
               sda_oe_d = 1'b0;
         endcase
      end
   end

   // Datapath: bit counter, shift register, pointer, write port and busy.
   // A START/STOP resets the counter without touching wr_valid, so a
   // partial byte is simply dropped. The pointer survives START so a
   // repeated-start read continues where the write left it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         ptr       <= '0;
         rw        <= 1'b0;
         busy      <= 1'b0;
         sda_oe    <= 1'b0;
         wr_valid  <= 1'b0;
         wr_reg    <= '0;
         wr_data   <= '0;
      end else begin
         wr_valid <= 1'b0;
         sda_oe   <= sda_oe_d;
         if (stop_det) begin
            bit_cnt <= '0;
            busy    <= 1'b0;
         end else if (start_det) begin
            bit_cnt <= '0;
            if (state == ST_IGNORE)
               busy <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  shift_reg <= rx_byte;
                  bit_cnt   <= bit_cnt + CNT_ONE;
                  if (bit_cnt == LAST_BIT) begin
                     if (state == ST_ADDR) begin
                        busy <= addr_match;
                        rw   <= rx_byte[RW_BIT];
                     end
                     if (state == ST_PTR)
                        ptr <= rx_byte[REG_AW-1:0];
                     if (state == ST_WDATA) begin
                        wr_valid <= 1'b1;
                        wr_reg   <= ptr;
                        wr_data  <= rx_byte;
                     end
                  end
               end
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK, ST_RDATA:
                  bit_cnt <= bit_cnt + CNT_ONE;
               ST_RDATA_ACK:
                  if (sda == ACK) begin
                     shift_reg <= rd_data;
                     bit_cnt   <= '0;
                  end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
                  if (bit_cnt == ACK_END) begin
                     bit_cnt <= '0;
                     if (state == ST_WDATA_ACK)
                        ptr <= ptr + PTR_ONE;
                     if (state == ST_ADDR_ACK && rw)
                        shift_reg <= rd_data;
                  end
               ST_RDATA:
                  if (bit_cnt == BYTE_END)
                     ptr <= ptr + PTR_ONE;
                  else if (bit_cnt != '0)
                     shift_reg <= shift_reg << 1;
               default: ;
            endcase
         end
      end
   end

endmodule
